// File: rtl/fp_cmp_issue.sv
// fp_cmp_issue: issues operand pairs to a fixed-latency go/done unit and queues its results in a credit-protected FIFO.
// Optional activity counters (stat_issued, stat_stalls) are built when FP_CMP_ISSUE_STATS_EN is defined.
module fp_cmp_issue #(
    parameter int LATENCY = 3,
    parameter int DEPTH   = 4,
    parameter int DATA_W  = 32,
    parameter int RES_W   = 3
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    output logic              unit_go,
    output logic [DATA_W-1:0] unit_a,
    output logic [DATA_W-1:0] unit_b,
    input  logic              unit_done,
    input  logic [RES_W-1:0]  unit_result,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [RES_W-1:0]  resp_data,
    output logic              err_spurious
`ifdef FP_CMP_ISSUE_STATS_EN
    ,
    output logic [31:0]       stat_issued,
    output logic [31:0]       stat_stalls
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int LW = $clog2(LATENCY + 1);

    typedef enum logic {FLUSH, RUN} state_t;

    state_t           state, state_nx;
    logic [LW-1:0]    flush_cnt, flush_nx;
    logic [CW-1:0]    inflight, inflight_nx, count, count_nx;
    logic [AW-1:0]    wptr, rptr;
    logic [RES_W-1:0] mem [DEPTH];
    logic             run, accept, done_ok, spurious, pop, full, push;

    assign unit_go    = accept;
    assign unit_a     = req_a;
    assign unit_b     = req_b;
    assign resp_valid = count != '0;
    assign resp_data  = mem[rptr];

    // next state, credit check and handshake decode; dones are ignored until the unit pipeline has flushed
    always_comb begin
        state_nx    = state;
        flush_nx    = flush_cnt;
        if (state == FLUSH) begin
            if (flush_cnt == '0) state_nx = RUN;
            else flush_nx = flush_cnt - LW'(1);
        end
        run         = state == RUN;
        req_ready   = run && ({1'b0, inflight} + {1'b0, count} < (CW+1)'(DEPTH));
        accept      = req_valid && req_ready;
        done_ok     = unit_done && run && inflight != '0;
        spurious    = unit_done && run && inflight == '0;
        pop         = resp_valid && resp_ready;
        full        = count == CW'(DEPTH) && !pop;
        push        = done_ok && !full;
        inflight_nx = inflight + CW'(accept) - CW'(done_ok);
        count_nx    = count + CW'(push) - CW'(pop);
    end

    // state, credit counters, FIFO pointers and sticky error
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state        <= FLUSH;
            flush_cnt    <= LW'(LATENCY);
            inflight     <= '0;
            count        <= '0;
            wptr         <= '0;
            rptr         <= '0;
            err_spurious <= 1'b0;
        end else begin
            state     <= state_nx;
            flush_cnt <= flush_nx;
            inflight  <= inflight_nx;
            count     <= count_nx;
            if (push) wptr <= wptr + AW'(1);
            if (pop) rptr <= rptr + AW'(1);
            if (spurious || (done_ok && full)) err_spurious <= 1'b1;
        end
    end

    // result storage needs no reset; count alone says which entries are live
    always_ff @(posedge clock) begin
        if (push) mem[wptr] <= unit_result;
    end

`ifdef FP_CMP_ISSUE_STATS_EN
    // accepted requests and stalled request cycles while running
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            stat_issued <= '0;
            stat_stalls <= '0;
        end else begin
            if (accept) stat_issued <= stat_issued + 32'd1;
            if (run && req_valid && !req_ready) stat_stalls <= stat_stalls + 32'd1;
        end
    end
`endif
endmodule
